clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_pkg.sv | 78 +++++++
 rtl/button_debounce.sv | 57 +++++
 rtl/clock_set_ctrl.sv | 155 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the 12-hour clock with button-driven time setting:
// mode encoding, BCD limits, digit blank masks and small BCD helpers.
package clock_pkg;

    // Operating mode; the numeric values are visible on the mode output.
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_t;

    // BCD limits for the time fields.
    localparam logic [7:0] BCD_MIN_MAX      = 8'h59;
    localparam logic [7:0] BCD_HOUR_MAX     = 8'h12;
    localparam logic [7:0] BCD_HOUR_PM_EDGE = 8'h11;

    // Values loaded on reset: 12:00:00 AM.
    localparam logic [7:0] BCD_HOUR_RESET = 8'h12;
    localparam logic [7:0] BCD_MIN_RESET  = 8'h00;

    // Seconds are kept in plain binary since they are never displayed.
    localparam logic [5:0] SEC_MAX = 6'd59;

    // Per-digit blank masks: bit0 = minute units ... bit3 = hour tens.
    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_HOUR = 4'b1100;
    localparam logic [3:0] BLANK_MIN  = 4'b0011;

    // Advance a BCD minute value, wrapping 59 -> 00.
    function automatic logic [7:0] bcd_min_inc(input logic [7:0] m);
        logic [7:0] r;
        if (m == BCD_MIN_MAX) begin
            r = 8'h00;
        end else if (m[3:0] == 4'd9) begin
            r = {m[7:4] + 4'd1, 4'd0};
        end else begin
            r = {m[7:4], m[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Advance a BCD hour value in 1..12, wrapping 12 -> 01.
    // The AM/PM flip at 11 -> 12 is handled by the caller.
    function automatic logic [7:0] bcd_hour_inc(input logic [7:0] h);
        logic [7:0] r;
        if (h == BCD_HOUR_MAX) begin
            r = 8'h01;
        end else if (h[3:0] == 4'd9) begin
            r = {h[7:4] + 4'd1, 4'd0};
        end else begin
            r = {h[7:4], h[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Mode sequence RUN -> SET_HOUR -> SET_MIN -> RUN.
    function automatic mode_t mode_advance(input mode_t m);
        mode_t r;
        case (m)
            MODE_RUN:      r = MODE_SET_HOUR;
            MODE_SET_HOUR: r = MODE_SET_MIN;
            default:       r = MODE_RUN;
        endcase
        return r;
    endfunction

    // Digits that flash while a field is being edited.
    function automatic logic [3:0] blank_mask(input mode_t m);
        logic [3:0] r;
        case (m)
            MODE_SET_HOUR: r = BLANK_HOUR;
            MODE_SET_MIN:  r = BLANK_MIN;
            default:       r = BLANK_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Single push-button front end: two-flop synchronizer, level debouncer and
// a one-cycle pulse on every debounced press (0 -> 1).
module button_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES
    // consecutive cycles; any bounce back to the old level restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_reg <= 1'b0;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            press_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
                press_reg <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/clock_set_ctrl.sv
// 12-hour BCD clock with a two-button setting interface. btn_mode walks
// RUN -> SET_HOUR -> SET_MIN -> RUN; btn_inc advances the field being edited,
// which flashes on the display while it is selected.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_CYCLES     = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_HALF      = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] zero_min,
    output logic [3:0] first_min,
    output logic [3:0] zero_hour,
    output logic [3:0] first_hour,
    output logic       pm,
    output logic [3:0] digit_blank,
    output logic [1:0] mode
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    localparam int NUM_BTN = 2;

    // Button index 0 is mode, index 1 is increment.
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press_vec;

    logic mode_evt;
    logic inc_evt;

    mode_t         mode_reg;
    logic [7:0]    hour_reg;
    logic [7:0]    min_reg;
    logic [5:0]    sec_reg;
    logic          pm_reg;
    logic [PW-1:0] presc_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          blank_phase_reg;
    logic [3:0]    digit_blank_reg;

    assign btn_raw = {btn_inc, btn_mode};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .rst_n(rst_n),
                .btn  (btn_raw[gi]),
                .press(press_vec[gi])
            );
        end
    endgenerate

    // A mode press always wins; a simultaneous inc press is dropped.
    assign mode_evt = press_vec[0];
    assign inc_evt  = press_vec[1] & ~press_vec[0];

    // Mode FSM plus the blink phase generator and the registered blank mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_reg        <= MODE_RUN;
            blink_cnt_reg   <= '0;
            blank_phase_reg <= 1'b0;
            digit_blank_reg <= BLANK_NONE;
        end else if (mode_evt) begin
            mode_reg        <= mode_advance(mode_reg);
            blink_cnt_reg   <= '0;
            blank_phase_reg <= 1'b0;
            digit_blank_reg <= BLANK_NONE;
        end else if (mode_reg == MODE_RUN || inc_evt) begin
            // Nothing flashes while running; an accepted edit shows the new
            // value immediately by restarting in the visible phase.
            blink_cnt_reg   <= '0;
            blank_phase_reg <= 1'b0;
            digit_blank_reg <= BLANK_NONE;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg   <= '0;
            blank_phase_reg <= ~blank_phase_reg;
            digit_blank_reg <= blank_phase_reg ? BLANK_NONE : blank_mask(mode_reg);
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    // Timekeeping: prescaled seconds with carries in RUN, field edits in SET.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hour_reg  <= BCD_HOUR_RESET;
            min_reg   <= BCD_MIN_RESET;
            sec_reg   <= '0;
            pm_reg    <= 1'b0;
            presc_reg <= '0;
        end else if (mode_evt) begin
            // Every mode change either enters a SET state or leaves SET_MIN;
            // in both cases the second count starts again from a clean zero.
            presc_reg <= '0;
            sec_reg   <= '0;
        end else if (mode_reg == MODE_RUN) begin
            if (presc_reg == PRESC_LAST) begin
                presc_reg <= '0;
                if (sec_reg == SEC_MAX) begin
                    sec_reg <= '0;
                    min_reg <= bcd_min_inc(min_reg);
                    if (min_reg == BCD_MIN_MAX) begin
                        hour_reg <= bcd_hour_inc(hour_reg);
                        if (hour_reg == BCD_HOUR_PM_EDGE) begin
                            pm_reg <= ~pm_reg;
                        end
                    end
                end else begin
                    sec_reg <= sec_reg + 6'd1;
                end
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
        end else begin
            presc_reg <= '0;
            sec_reg   <= '0;
            if (inc_evt) begin
                case (mode_reg)
                    MODE_SET_HOUR: begin
                        hour_reg <= bcd_hour_inc(hour_reg);
                        if (hour_reg == BCD_HOUR_PM_EDGE) begin
                            pm_reg <= ~pm_reg;
                        end
                    end
                    MODE_SET_MIN: begin
                        // Editing minutes never carries into the hour.
                        min_reg <= bcd_min_inc(min_reg);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign zero_min    = min_reg[3:0];
    assign first_min   = min_reg[7:4];
    assign zero_hour   = hour_reg[3:0];
    assign first_hour  = hour_reg[7:4];
    assign pm          = pm_reg;
    assign digit_blank = digit_blank_reg;
    assign mode        = mode_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with small timing parameters. A behavioural time
// model pushes expected display words into a queue as stimulus is applied;
// they are popped and compared once the DUT has had time to respond.
module tb_clock_set_ctrl;

    localparam int TICK     = 10;
    localparam int DEB      = 4;
    localparam int BLINK    = 8;

    // Display word: {pm, hour BCD, minute BCD, mode, digit_blank}
    localparam logic [22:0] MASK_ALL     = 23'h7FFFFF;
    localparam logic [22:0] MASK_NOBLANK = 23'h7FFFF0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] zero_min;
    logic [3:0] first_min;
    logic [3:0] zero_hour;
    logic [3:0] first_hour;
    logic       pm;
    logic [3:0] digit_blank;
    logic [1:0] mode;

    clock_set_ctrl #(
        .TICK_CYCLES    (TICK),
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_HALF     (BLINK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .zero_min   (zero_min),
        .first_min  (first_min),
        .zero_hour  (zero_hour),
        .first_hour (first_hour),
        .pm         (pm),
        .digit_blank(digit_blank),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int   m_hour = 12;
    int   m_min  = 0;
    logic m_pm   = 1'b0;
    int   m_mode = 0;

    typedef struct {
        string       tag;
        logic [22:0] exp;
        logic [22:0] mask;
    } sb_t;

    sb_t sb_q[$];

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [22:0] model_word(input logic [3:0] blank);
        logic [1:0] md;
        md = 2'(m_mode);
        return {m_pm, to_bcd(m_hour), to_bcd(m_min), md, blank};
    endfunction

    function automatic logic [22:0] dut_word();
        return {pm, first_hour, zero_hour, first_min, zero_min, mode, digit_blank};
    endfunction

    task automatic tb_check(input string tag, input logic [22:0] got, input logic [22:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    task automatic sb_push(input string tag, input logic [22:0] mask, input logic [3:0] blank);
        sb_t e;
        e.tag  = tag;
        e.exp  = model_word(blank);
        e.mask = mask;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop();
        sb_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            tb_check(e.tag, dut_word() & e.mask, e.exp & e.mask);
        end
    endtask

    task automatic m_hour_inc();
        if (m_hour == 11) begin
            m_hour = 12;
            m_pm   = ~m_pm;
        end else if (m_hour == 12) begin
            m_hour = 1;
        end else begin
            m_hour++;
        end
    endtask

    task automatic m_minute_tick();
        if (m_min == 59) begin
            m_min = 0;
            m_hour_inc();
        end else begin
            m_min++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One clean 6-cycle button press; response checked once debounce settles.
    task automatic press(input logic p_mode, input logic p_inc, input string tag);
        if (p_mode) begin
            m_mode = (m_mode + 1) % 3;
        end else if (p_inc) begin
            if (m_mode == 1) m_hour_inc();
            else if (m_mode == 2) m_min = (m_min + 1) % 60;
        end
        sb_push(tag, MASK_NOBLANK, 4'b0000);
        btn_mode = p_mode;
        btn_inc  = p_inc;
        cycles(6);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cycles(16);
        sb_pop();
    endtask

    // Mode press that returns on the exact cycle the new mode appears.
    task automatic mode_sync(input string tag);
        m_mode = (m_mode + 1) % 3;
        sb_push(tag, MASK_ALL, 4'b0000);
        btn_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) btn_mode = 1'b0;
            if (int'(mode) == m_mode) break;
        end
        btn_mode = 1'b0;
        sb_pop();
    endtask

    // From a fresh RUN entry: minute must hold for 599 cycles, carry on 600.
    task automatic run_minute(input string tag_pre, input string tag_post);
        cycles(TICK * 60 - 1);
        sb_push(tag_pre, MASK_ALL, 4'b0000);
        sb_pop();
        cycles(1);
        m_minute_tick();
        sb_push(tag_post, MASK_ALL, 4'b0000);
        sb_pop();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and tick timing from reset release
        rst_n = 1'b0;
        cycles(3);
        sb_push("reset_state", MASK_ALL, 4'b0000);
        sb_pop();
        rst_n = 1'b1;
        run_minute("reset_pre_carry", "reset_tick_carry");

        // Too-short press is filtered; inc is ignored while running
        btn_mode = 1'b1;
        cycles(3);
        btn_mode = 1'b0;
        cycles(16);
        sb_push("short_mode_press", MASK_ALL, 4'b0000);
        sb_pop();
        press(1'b0, 1'b1, "inc_in_run_ignored");

        // Enter SET_HOUR and follow the blink phase
        mode_sync("enter_set_hour");
        cycles(BLINK - 1);
        sb_push("blink_visible_7", MASK_ALL, 4'b0000);
        sb_pop();
        cycles(1);
        sb_push("blink_blank_8", MASK_ALL, 4'b1100);
        sb_pop();
        cycles(BLINK - 1);
        sb_push("blink_blank_15", MASK_ALL, 4'b1100);
        sb_pop();
        cycles(1);
        sb_push("blink_visible_16", MASK_ALL, 4'b0000);
        sb_pop();

        // Hours 12 AM -> 11 AM -> 12 PM -> 01 PM
        for (int i = 0; i < 11; i++) press(1'b0, 1'b1, "set_hour_inc");
        press(1'b0, 1'b1, "hour_11_to_12_pm");
        press(1'b0, 1'b1, "hour_12_to_01");

        // Minutes up to 59 then wrap without hour carry
        press(1'b1, 1'b0, "to_set_min");
        while (m_min != 59) press(1'b0, 1'b1, "set_min_inc");
        press(1'b0, 1'b1, "min_59_wrap_no_carry");

        // Simultaneous mode and inc in SET_HOUR
        press(1'b1, 1'b0, "to_run");
        press(1'b1, 1'b0, "to_set_hour");
        press(1'b1, 1'b1, "mode_and_inc_same_cycle");

        // Build 11:59 AM and run through noon
        while (m_min != 59) press(1'b0, 1'b1, "set_min_inc");
        press(1'b1, 1'b0, "to_run");
        press(1'b1, 1'b0, "to_set_hour");
        while (!(m_hour == 11 && m_pm == 1'b0)) press(1'b0, 1'b1, "set_hour_inc");
        press(1'b1, 1'b0, "to_set_min");
        mode_sync("run_from_1159am");
        run_minute("pre_noon", "noon_pm_toggle");

        // Build 12:59 PM and run into 01:00 PM
        press(1'b1, 1'b0, "to_set_hour");
        press(1'b1, 1'b0, "to_set_min");
        while (m_min != 59) press(1'b0, 1'b1, "set_min_inc");
        mode_sync("run_from_1259pm");
        run_minute("pre_one_pm", "one_pm_no_toggle");

        // Reset in SET_MIN at 07:42 PM
        press(1'b1, 1'b0, "to_set_hour");
        while (m_hour != 7) press(1'b0, 1'b1, "set_hour_inc");
        press(1'b1, 1'b0, "to_set_min");
        while (m_min != 42) press(1'b0, 1'b1, "set_min_inc");
        sb_push("at_0742pm_set_min", MASK_NOBLANK, 4'b0000);
        sb_pop();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        m_hour = 12;
        m_min  = 0;
        m_pm   = 1'b0;
        m_mode = 0;
        cycles(1);
        sb_push("reset_in_set_min", MASK_ALL, 4'b0000);
        sb_pop();

        // Reset in the middle of a debounce produces no event afterwards
        btn_mode = 1'b1;
        cycles(4);
        rst_n = 1'b0;
        cycles(3);
        btn_mode = 1'b0;
        rst_n = 1'b1;
        cycles(20);
        sb_push("reset_mid_debounce", MASK_ALL, 4'b0000);
        sb_pop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
